// File: rtl/qnigma_sreg_pkg.sv
// Shared types for the handshaked serial/parallel shift register.
package qnigma_sreg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FILL,
        FULL
    } sreg_state_t;

endpackage

// File: rtl/qnigma_shiftreg.sv
// Element-wide shift register with parallel load; a load and a shift in the same
// cycle shift the freshly loaded word.
module qnigma_shiftreg #(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 8,
    parameter int RIGHT  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [LENGTH*WIDTH-1:0] load_data,
    input  logic                    shift,
    input  logic [WIDTH-1:0]        shift_in,
    output logic [LENGTH*WIDTH-1:0] par,
    output logic [WIDTH-1:0]        ser
);

    logic [LENGTH*WIDTH-1:0] reg_q;
    logic [LENGTH*WIDTH-1:0] reg_d;
    logic [LENGTH*WIDTH-1:0] base;

    always_comb begin
        base  = load ? load_data : reg_q;
        reg_d = base;
        if (shift) begin
            if (RIGHT != 0) begin
                reg_d = {shift_in, base[LENGTH*WIDTH-1:WIDTH]};
            end else begin
                reg_d = {base[(LENGTH-1)*WIDTH-1:0], shift_in};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign par = reg_q;
    assign ser = (RIGHT != 0) ? reg_q[WIDTH-1:0] : reg_q[LENGTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/qnigma_shiftreg_stream.sv
// Valid/ready wrapper around qnigma_shiftreg: drains a loaded word serially or
// collects serial elements into a word, tracking occupancy in cnt.
module qnigma_shiftreg_stream
    import qnigma_sreg_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 8,
    parameter int RIGHT  = 0,
    parameter int CNT_W  = $clog2(LENGTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [LENGTH*WIDTH-1:0] par_i,
    input  logic [CNT_W-1:0]        par_len,
    input  logic                    par_i_val,
    output logic                    par_i_rdy,
    output logic [WIDTH-1:0]        ser_o,
    output logic                    ser_o_last,
    output logic                    ser_o_val,
    input  logic                    ser_o_rdy,
    input  logic [WIDTH-1:0]        ser_i,
    input  logic                    ser_i_last,
    input  logic                    ser_i_val,
    output logic                    ser_i_rdy,
    output logic [LENGTH*WIDTH-1:0] par_o,
    output logic [CNT_W-1:0]        par_o_cnt,
    output logic                    par_o_val,
    input  logic                    par_o_rdy
);

    sreg_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] eff_len;

    logic load_hs, clr_hs, drain_hs, fill_hs, word_hs;
    logic                    sr_load, sr_shift;
    logic [LENGTH*WIDTH-1:0] sr_load_data;
    logic [WIDTH-1:0]        sr_shift_in;

    always_comb begin
        if (par_len == '0 || par_len > CNT_W'(LENGTH)) begin
            eff_len = CNT_W'(LENGTH);
        end else begin
            eff_len = par_len;
        end
    end

    // Outputs depend on state/cnt only, except the IDLE ser_i_rdy arbitration term.
    always_comb begin
        par_i_rdy  = (state_q == IDLE);
        ser_i_rdy  = ((state_q == IDLE) && !par_i_val) || (state_q == FILL);
        ser_o_val  = (state_q == DRAIN);
        ser_o_last = (state_q == DRAIN) && (cnt_q == CNT_W'(1));
        par_o_val  = (state_q == FULL);
        par_o_cnt  = (state_q == FULL) ? cnt_q : '0;
    end

    assign load_hs  = (state_q == IDLE) && par_i_val;
    assign clr_hs   = (state_q == IDLE) && !par_i_val && ser_i_val;
    assign drain_hs = (state_q == DRAIN) && ser_o_rdy;
    assign fill_hs  = (state_q == FILL) && ser_i_val;
    assign word_hs  = (state_q == FULL) && par_o_rdy;

    // A clear is a load of zeros followed by a shift of the first element.
    assign sr_load      = flush || load_hs || clr_hs;
    assign sr_load_data = (load_hs && !flush) ? par_i : '0;
    assign sr_shift     = !flush && (drain_hs || fill_hs || clr_hs);
    assign sr_shift_in  = (state_q == DRAIN) ? '0 : ser_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (load_hs) begin
                    state_d = DRAIN;
                    cnt_d   = eff_len;
                end else if (clr_hs) begin
                    state_d = ser_i_last ? FULL : FILL;
                    cnt_d   = CNT_W'(1);
                end
            end
            DRAIN: begin
                if (drain_hs) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            FILL: begin
                if (fill_hs) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (ser_i_last || cnt_q == CNT_W'(LENGTH - 1)) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (word_hs) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    qnigma_shiftreg #(
        .WIDTH (WIDTH),
        .LENGTH(LENGTH),
        .RIGHT (RIGHT)
    ) u_sreg (
        .clk      (clk),
        .rst      (rst),
        .load     (sr_load),
        .load_data(sr_load_data),
        .shift    (sr_shift),
        .shift_in (sr_shift_in),
        .par      (par_o),
        .ser      (ser_o)
    );

endmodule

// File: tb/tb_qnigma_shiftreg_stream.sv
// Bench for qnigma_shiftreg_stream: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based model.
module tb_qnigma_shiftreg_stream;

    localparam int W     = 8;
    localparam int L     = 8;
    localparam int R     = 0;
    localparam int CNT_W = $clog2(L + 1);
    localparam int PW    = L * W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [PW-1:0]    par_i = '0;
    logic [CNT_W-1:0] par_len = '0;
    logic             par_i_val = 1'b0;
    logic             par_i_rdy;
    logic [W-1:0]     ser_o;
    logic             ser_o_last;
    logic             ser_o_val;
    logic             ser_o_rdy = 1'b0;
    logic [W-1:0]     ser_i = '0;
    logic             ser_i_last = 1'b0;
    logic             ser_i_val = 1'b0;
    logic             ser_i_rdy;
    logic [PW-1:0]    par_o;
    logic [CNT_W-1:0] par_o_cnt;
    logic             par_o_val;
    logic             par_o_rdy = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    qnigma_shiftreg_stream #(
        .WIDTH (W),
        .LENGTH(L),
        .RIGHT (R)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .par_i     (par_i),
        .par_len   (par_len),
        .par_i_val (par_i_val),
        .par_i_rdy (par_i_rdy),
        .ser_o     (ser_o),
        .ser_o_last(ser_o_last),
        .ser_o_val (ser_o_val),
        .ser_o_rdy (ser_o_rdy),
        .ser_i     (ser_i),
        .ser_i_last(ser_i_last),
        .ser_i_val (ser_i_val),
        .ser_i_rdy (ser_i_rdy),
        .par_o     (par_o),
        .par_o_cnt (par_o_cnt),
        .par_o_val (par_o_val),
        .par_o_rdy (par_o_rdy)
    );

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] elem(input logic [PW-1:0] word, input int j);
        return word[j*W +: W];
    endfunction

    // Model: mode 0 idle, 1 drain, 2 fill, 3 full. dq holds elements still to be
    // emitted in order; cq holds collected elements oldest first.
    int          m_mode = 0;
    logic [W-1:0] dq[$];
    logic [W-1:0] cq[$];
    bit          m_zero = 1'b1;
    bit          armed  = 1'b0;

    function automatic logic [PW-1:0] collected_word();
        logic [PW-1:0] w;
        int k;
        int pos;
        w = '0;
        k = cq.size();
        for (int i = 0; i < k; i++) begin
            pos = (R != 0) ? (L - k + i) : (k - 1 - i);
            w[pos*W +: W] = cq[i];
        end
        return w;
    endfunction

    initial forever begin
        int n;
        @(posedge clk);
        if (rst || flush) begin
            m_mode = 0;
            dq.delete();
            cq.delete();
            m_zero = 1'b1;
        end else begin
            case (m_mode)
                0: begin
                    if (par_i_val) begin
                        n = (int'(par_len) == 0 || int'(par_len) > L) ? L : int'(par_len);
                        dq.delete();
                        for (int k = 0; k < n; k++) begin
                            dq.push_back((R != 0) ? elem(par_i, k) : elem(par_i, L - 1 - k));
                        end
                        m_mode = 1;
                        m_zero = 1'b0;
                    end else if (ser_i_val) begin
                        cq.delete();
                        cq.push_back(ser_i);
                        m_mode = ser_i_last ? 3 : 2;
                        m_zero = 1'b0;
                    end
                end
                1: begin
                    if (ser_o_rdy) begin
                        dq.delete(0);
                        if (dq.size() == 0) m_mode = 0;
                    end
                end
                2: begin
                    if (ser_i_val) begin
                        cq.push_back(ser_i);
                        if (ser_i_last || cq.size() == L) m_mode = 3;
                    end
                end
                default: begin
                    if (par_o_rdy) m_mode = 0;
                end
            endcase
        end
        if (rst) armed = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (armed) begin
            check("m_par_i_rdy", PW'(par_i_rdy), PW'(m_mode == 0));
            check("m_ser_i_rdy", PW'(ser_i_rdy), PW'((m_mode == 0 && !par_i_val) || m_mode == 2));
            check("m_ser_o_val", PW'(ser_o_val), PW'(m_mode == 1));
            check("m_ser_o_last", PW'(ser_o_last), PW'(m_mode == 1 && dq.size() == 1));
            check("m_par_o_val", PW'(par_o_val), PW'(m_mode == 3));
            check("m_par_o_cnt", PW'(par_o_cnt), (m_mode == 3) ? PW'(cq.size()) : '0);
            if (m_mode == 1 && dq.size() > 0) check("m_ser_o", PW'(ser_o), PW'(dq[0]));
            if (m_mode == 3) check("m_par_o", par_o, collected_word());
            if (m_zero) check("m_par_o_zero", par_o, '0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_clean(input string tag);
        @(negedge clk);
        check({tag, "_par_o"}, par_o, '0);
        check({tag, "_ser_o_val"}, PW'(ser_o_val), '0);
        check({tag, "_par_o_val"}, PW'(par_o_val), '0);
        check({tag, "_par_o_cnt"}, PW'(par_o_cnt), '0);
        check({tag, "_par_i_rdy"}, PW'(par_i_rdy), PW'(1));
        check({tag, "_ser_i_rdy"}, PW'(ser_i_rdy), PW'(1));
    endtask

    localparam logic [PW-1:0] RAMP = 64'h0706_0504_0302_0100;

    initial begin
        int e;
        logic [PW-1:0] held;

        step();
        step();
        check_idle_clean("reset");
        check("reset_ser_o_last", PW'(ser_o_last), '0);
        rst = 1'b0;
        step();

        // Full drain of the ramp word.
        par_i = RAMP;
        par_len = '0;
        par_i_val = 1'b1;
        step();
        par_i_val = 1'b0;
        ser_o_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("drain8_ser_o", PW'(ser_o), PW'(7 - i));
            check("drain8_last", PW'(ser_o_last), PW'(i == 7));
            step();
        end
        @(negedge clk);
        check("drain8_idle", PW'(par_i_rdy), PW'(1));
        check("drain8_val_low", PW'(ser_o_val), '0);

        // Three-element drain with a stalling sink.
        par_len = CNT_W'(3);
        par_i_val = 1'b1;
        ser_o_rdy = 1'b0;
        step();
        par_i_val = 1'b0;
        e = 0;
        for (int c = 0; c < 20 && e < 3; c++) begin
            ser_o_rdy = (c % 2 == 1);
            @(negedge clk);
            check("drain3_ser_o", PW'(ser_o), PW'(7 - e));
            check("drain3_last", PW'(ser_o_last), PW'(e == 2));
            step();
            if (ser_o_rdy) e++;
        end
        ser_o_rdy = 1'b0;
        check("drain3_count", PW'(e), PW'(3));
        @(negedge clk);
        check("drain3_done", PW'(ser_o_val), '0);

        // Early-terminated collect of A, B, C.
        ser_i_val = 1'b1;
        ser_i = 8'h0A;
        step();
        ser_i = 8'h0B;
        step();
        ser_i = 8'h0C;
        ser_i_last = 1'b1;
        step();
        ser_i = 8'hEE;
        ser_i_last = 1'b0;
        @(negedge clk);
        check("abc_val", PW'(par_o_val), PW'(1));
        check("abc_cnt", PW'(par_o_cnt), PW'(3));
        check("abc_word", par_o, 64'h0000_0000_000A_0B0C);
        held = par_o;
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            check("abc_hold_word", par_o, held);
            check("abc_hold_rdy", PW'(ser_i_rdy), '0);
        end
        ser_i_val = 1'b0;
        par_o_rdy = 1'b1;
        step();
        par_o_rdy = 1'b0;

        // Collect a full word without a last marker.
        ser_i_val = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ser_i = W'(8'h10 + i);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full8_cnt", PW'(par_o_cnt), PW'(8));
            check("full8_rdy", PW'(ser_i_rdy), '0);
            step();
        end
        check("full8_word", par_o, 64'h1011_1213_1415_1617);
        ser_i_val = 1'b0;
        par_o_rdy = 1'b1;
        step();
        par_o_rdy = 1'b0;

        // Simultaneous load and collect requests in IDLE.
        par_i = RAMP;
        par_len = '0;
        par_i_val = 1'b1;
        ser_i_val = 1'b1;
        ser_i = 8'h55;
        @(negedge clk);
        check("both_ser_i_rdy", PW'(ser_i_rdy), '0);
        check("both_par_i_rdy", PW'(par_i_rdy), PW'(1));
        step();
        par_i_val = 1'b0;
        ser_i_val = 1'b0;
        @(negedge clk);
        check("both_drain", PW'(ser_o_val), PW'(1));
        check("both_first", PW'(ser_o), PW'(7));

        // Flush after two drained elements.
        ser_o_rdy = 1'b1;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        ser_o_rdy = 1'b0;
        check_idle_clean("flush");

        // Reset in the middle of a collect.
        ser_i_val = 1'b1;
        ser_i = 8'h33;
        step();
        step();
        ser_i_val = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_clean("rst_fill");

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            par_i      = {$urandom(), $urandom()};
            par_len    = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
            par_i_val  = ($urandom_range(0, 3) == 0);
            ser_i      = W'($urandom());
            ser_i_val  = ($urandom_range(0, 1) == 0);
            ser_i_last = ($urandom_range(0, 4) == 0);
            ser_o_rdy  = ($urandom_range(0, 4) < 3);
            par_o_rdy  = ($urandom_range(0, 4) < 2);
            flush      = ($urandom_range(0, 49) == 0);
            step();
        end
        par_i_val = 1'b0;
        ser_i_val = 1'b0;
        flush = 1'b0;
        ser_o_rdy = 1'b1;
        par_o_rdy = 1'b1;
        for (int i = 0; i < 12; i++) step();
        @(negedge clk);
        check("final_idle", PW'(par_i_rdy), PW'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
